// File: rtl/hazard_forward_unit_pkg.sv
// Shared select codes, instruction field positions and the shadow-stage record.
// Imported by the interface-facing top and the forwarding selector.
package hazard_forward_unit_pkg;

   localparam logic [1:0] FWD_REG   = 2'b00;
   localparam logic [1:0] FWD_WB    = 2'b01;
   localparam logic [1:0] FWD_EXMEM = 2'b10;

   localparam int RS_MSB = 25;
   localparam int RS_LSB = 21;
   localparam int RT_MSB = 20;
   localparam int RT_LSB = 16;

   localparam logic [4:0] REG_ZERO = 5'd0;

   typedef struct packed {
      logic [4:0] dest;
      logic       reg_write;
      logic       mem_read;
   } shadow_t;

   localparam shadow_t SHADOW_BUBBLE = '0;

endpackage

// File: rtl/hazard_forward_unit_if.sv
// ID-stage instruction info in, operand selects / pipeline controls / perf counters out.
// master drives ID info (pipeline side), slave is the hazard unit.
interface hazard_forward_unit_if #(parameter int CNT_W = 16);

   logic [31:0]      id_instr;
   logic [4:0]       id_dest;
   logic             id_reg_write;
   logic             id_mem_read;
   logic             id_uses_rt;
   logic             branch_taken;
   logic [1:0]       Forward_A;
   logic [1:0]       Forward_B;
   logic             pc_write;
   logic             if_id_write;
   logic             if_id_flush;
   logic             id_ex_flush;
   logic [CNT_W-1:0] stall_count;
   logic [CNT_W-1:0] flush_count;

   modport master (
      output id_instr, id_dest, id_reg_write, id_mem_read, id_uses_rt, branch_taken,
      input  Forward_A, Forward_B, pc_write, if_id_write, if_id_flush, id_ex_flush,
             stall_count, flush_count
   );

   modport slave (
      input  id_instr, id_dest, id_reg_write, id_mem_read, id_uses_rt, branch_taken,
      output Forward_A, Forward_B, pc_write, if_id_write, if_id_flush, id_ex_flush,
             stall_count, flush_count
   );

endinterface

// File: rtl/hazard_forward_unit_fwd_select.sv
// Combinational operand-source select for one source register; no latency, no backpressure.
// The EX-stage producer is newer than the MEM-stage one, so it takes priority.
module hazard_forward_unit_fwd_select
   import hazard_forward_unit_pkg::*;
(
   input  logic [4:0] src,
   input  logic [4:0] ex_dest,
   input  logic       ex_reg_write,
   input  logic [4:0] mem_dest,
   input  logic       mem_reg_write,
   output logic [1:0] fwd
);

   always_comb begin
      fwd = FWD_REG;
      if (ex_reg_write && (ex_dest != REG_ZERO) && (ex_dest == src)) begin
         fwd = FWD_EXMEM;
      end else if (mem_reg_write && (mem_dest != REG_ZERO) && (mem_dest == src)) begin
         fwd = FWD_WB;
      end
   end

endmodule

// File: rtl/hazard_forward_unit.sv
// Hazard/forwarding unit beside ID/EX: forward codes registered on the ID->EX edge (valid while instr is in EX);
// load-use stalls hold PC and IF/ID for one cycle and insert a bubble; taken branches flush IF/ID unless stalled.
module hazard_forward_unit
   import hazard_forward_unit_pkg::*;
#(
   parameter int CNT_W = 16
) (
   input  logic                 clk,
   input  logic                 reset,
   hazard_forward_unit_if.slave hif
);

   shadow_t          ex_q, ex_d, mem_q, mem_d, wb_q, wb_d;
   logic [1:0]       fwd_a_q, fwd_a_d, fwd_b_q, fwd_b_d;
   logic [1:0]       sel_a, sel_b;
   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;
   logic [4:0]       rs, rt;
   logic             stall, flush;
   logic             unused_bits;

   assign rs = hif.id_instr[RS_MSB:RS_LSB];
   assign rt = hif.id_instr[RT_MSB:RT_LSB];

   // Only a load one stage ahead can't be forwarded in time; anything older reaches EX via forwarding.
   assign stall = ex_q.mem_read && (ex_q.dest != REG_ZERO) &&
                  ((ex_q.dest == rs) || (hif.id_uses_rt && (ex_q.dest == rt)));
   assign flush = hif.branch_taken && !stall && reset;

   hazard_forward_unit_fwd_select u_sel_a (
      .src          (rs),
      .ex_dest      (ex_q.dest),
      .ex_reg_write (ex_q.reg_write),
      .mem_dest     (mem_q.dest),
      .mem_reg_write(mem_q.reg_write),
      .fwd          (sel_a)
   );

   hazard_forward_unit_fwd_select u_sel_b (
      .src          (rt),
      .ex_dest      (ex_q.dest),
      .ex_reg_write (ex_q.reg_write),
      .mem_dest     (mem_q.dest),
      .mem_reg_write(mem_q.reg_write),
      .fwd          (sel_b)
   );

   always_comb begin
      ex_d = SHADOW_BUBBLE;
      if (!stall) begin
         ex_d = '{dest: hif.id_dest, reg_write: hif.id_reg_write, mem_read: hif.id_mem_read};
      end
      mem_d   = ex_q;
      wb_d    = mem_q;
      fwd_a_d = stall ? FWD_REG : sel_a;
      fwd_b_d = stall ? FWD_REG : sel_b;

      stall_cnt_d = stall_cnt_q;
      if (stall && (stall_cnt_q != {CNT_W{1'b1}})) begin
         stall_cnt_d = stall_cnt_q + CNT_W'(1);
      end
      flush_cnt_d = flush_cnt_q;
      if (flush && (flush_cnt_q != {CNT_W{1'b1}})) begin
         flush_cnt_d = flush_cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         ex_q        <= SHADOW_BUBBLE;
         mem_q       <= SHADOW_BUBBLE;
         wb_q        <= SHADOW_BUBBLE;
         fwd_a_q     <= FWD_REG;
         fwd_b_q     <= FWD_REG;
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         ex_q        <= ex_d;
         mem_q       <= mem_d;
         wb_q        <= wb_d;
         fwd_a_q     <= fwd_a_d;
         fwd_b_q     <= fwd_b_d;
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   // WB shadow and the non-register instruction fields are carried but not consumed here.
   assign unused_bits = ^{hif.id_instr[31:26], hif.id_instr[15:0], wb_q, mem_q.mem_read};

   assign hif.Forward_A   = fwd_a_q;
   assign hif.Forward_B   = fwd_b_q;
   assign hif.pc_write    = !stall;
   assign hif.if_id_write = !stall;
   assign hif.id_ex_flush = stall;
   assign hif.if_id_flush = flush;
   assign hif.stall_count = stall_cnt_q;
   assign hif.flush_count = flush_cnt_q;

endmodule

// File: tb/tb_hazard_forward_unit.sv
// Directed program fragments plus random traffic, checked every cycle against an instruction-level model.
module tb_hazard_forward_unit;

   localparam int CNT_W = 4;
   localparam int CMAX  = 15;

   logic clk = 1'b0;
   logic reset = 1'b0;
   always #5 clk = ~clk;

   hazard_forward_unit_if #(.CNT_W(CNT_W)) hif();

   hazard_forward_unit #(.CNT_W(CNT_W)) dut (
      .clk  (clk),
      .reset(reset),
      .hif  (hif)
   );

   int total = 0;
   int bad   = 0;

   // Model: the two instructions ahead of ID (distance 1 = in EX, distance 2 = in MEM)
   int m_dest [2];
   bit m_rw   [2];
   bit m_mr   [2];
   int m_fa, m_fb, m_sc, m_fc;

   task automatic model_clear();
      for (int i = 0; i < 2; i++) begin
         m_dest[i] = 0;
         m_rw[i]   = 1'b0;
         m_mr[i]   = 1'b0;
      end
      m_fa = 0;
      m_fb = 0;
      m_sc = 0;
      m_fc = 0;
   endtask

   // Newest in-flight writer of src supplies the value; $0 is a constant.
   function automatic int ref_fwd(int src);
      if (src == 0) return 0;
      if (m_rw[0] && m_dest[0] == src) return 2;
      if (m_rw[1] && m_dest[1] == src) return 1;
      return 0;
   endfunction

   function automatic bit ref_stall(int rs, int rt, bit urt);
      return m_mr[0] && (m_dest[0] != 0) && ((m_dest[0] == rs) || (urt && (m_dest[0] == rt)));
   endfunction

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step(int rs, int rt, int dest, bit rw, bit mr, bit urt, bit br, bit rst);
      bit st;
      int nfa, nfb;
      @(posedge clk);
      #1;
      hif.id_instr     = {6'd0, 5'(rs), 5'(rt), 16'h1234};
      hif.id_dest      = 5'(dest);
      hif.id_reg_write = rw;
      hif.id_mem_read  = mr;
      hif.id_uses_rt   = urt;
      hif.branch_taken = br;
      reset            = rst;
      #5;
      st = ref_stall(rs, rt, urt);
      chk("forward_a",   32'(hif.Forward_A),   32'(m_fa));
      chk("forward_b",   32'(hif.Forward_B),   32'(m_fb));
      chk("pc_write",    32'(hif.pc_write),    32'(!st));
      chk("if_id_write", 32'(hif.if_id_write), 32'(!st));
      chk("id_ex_flush", 32'(hif.id_ex_flush), 32'(st));
      chk("if_id_flush", 32'(hif.if_id_flush), 32'(br && !st && rst));
      chk("stall_count", 32'(hif.stall_count), 32'(m_sc));
      chk("flush_count", 32'(hif.flush_count), 32'(m_fc));
      if (!rst) begin
         model_clear();
      end else begin
         nfa = st ? 0 : ref_fwd(rs);
         nfb = st ? 0 : ref_fwd(rt);
         if (st && m_sc < CMAX) m_sc++;
         if (br && !st && m_fc < CMAX) m_fc++;
         m_dest[1] = m_dest[0];
         m_rw[1]   = m_rw[0];
         m_mr[1]   = m_mr[0];
         m_dest[0] = st ? 0 : dest;
         m_rw[0]   = st ? 1'b0 : rw;
         m_mr[0]   = st ? 1'b0 : mr;
         m_fa = nfa;
         m_fb = nfb;
      end
   endtask

   task automatic nop();
      step(0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
   endtask

   task automatic alu(int rs, int rt, int dest);
      step(rs, rt, dest, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
   endtask

   task automatic lw(int rs, int dest);
      step(rs, dest, dest, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
   endtask

   initial begin
      hif.id_instr     = '0;
      hif.id_dest      = '0;
      hif.id_reg_write = 1'b0;
      hif.id_mem_read  = 1'b0;
      hif.id_uses_rt   = 1'b0;
      hif.branch_taken = 1'b0;
      model_clear();

      step(0, 0, 0, 0, 0, 0, 0, 1'b0);
      step(0, 0, 0, 0, 0, 0, 0, 1'b0);
      chk("lit_reset_pc_write", 32'(hif.pc_write), 32'd1);
      chk("lit_reset_stall_count", 32'(hif.stall_count), 32'd0);

      // add $3,$1,$2 ; sub $4,$3,$5
      alu(1, 2, 3); alu(3, 5, 4); nop();
      chk("lit_exmem_fwd_a", 32'(hif.Forward_A), 32'd2);
      chk("lit_exmem_fwd_b", 32'(hif.Forward_B), 32'd0);

      // add $3 ; nop ; or $6,$7,$3
      alu(1, 2, 3); nop(); alu(7, 3, 6); nop();
      chk("lit_wb_fwd_b", 32'(hif.Forward_B), 32'd1);
      chk("lit_wb_fwd_a", 32'(hif.Forward_A), 32'd0);

      // lw $2,0($1) ; add $4,$2,$5
      lw(1, 2); alu(2, 5, 4);
      chk("lit_lu_pc_write", 32'(hif.pc_write), 32'd0);
      chk("lit_lu_if_id_write", 32'(hif.if_id_write), 32'd0);
      chk("lit_lu_id_ex_flush", 32'(hif.id_ex_flush), 32'd1);
      alu(2, 5, 4);
      chk("lit_lu_stall_count", 32'(hif.stall_count), 32'd1);
      chk("lit_lu_one_cycle", 32'(hif.id_ex_flush), 32'd0);
      nop();
      chk("lit_lu_fwd_a", 32'(hif.Forward_A), 32'd1);

      // lw $2 ; lw $2,4($2) (rt unused) ; then addi with rt=$2 unused
      lw(1, 2); lw(2, 2);
      chk("lit_lwlw_stall", 32'(hif.id_ex_flush), 32'd1);
      lw(2, 2);
      chk("lit_lwlw_release", 32'(hif.id_ex_flush), 32'd0);
      step(6, 2, 5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
      chk("lit_rt_unused_nostall", 32'(hif.id_ex_flush), 32'd0);

      // $0 never forwarded; newest producer wins
      alu(1, 1, 0); alu(0, 0, 4); nop();
      chk("lit_r0_fwd_a", 32'(hif.Forward_A), 32'd0);
      chk("lit_r0_fwd_b", 32'(hif.Forward_B), 32'd0);
      alu(1, 2, 3); alu(1, 2, 3); alu(3, 3, 5); nop();
      chk("lit_newest_fwd_a", 32'(hif.Forward_A), 32'd2);
      chk("lit_newest_fwd_b", 32'(hif.Forward_B), 32'd2);

      // branch without and with a concurrent stall
      step(1, 2, 7, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
      chk("lit_br_flush", 32'(hif.if_id_flush), 32'd1);
      nop();
      chk("lit_br_flush_count", 32'(hif.flush_count), 32'd1);
      lw(1, 2);
      step(2, 0, 0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
      chk("lit_br_stall_noflush", 32'(hif.if_id_flush), 32'd0);
      step(2, 0, 0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
      chk("lit_br_reeval_flush", 32'(hif.if_id_flush), 32'd1);

      // reset mid-run while a load-use hazard is pending
      lw(1, 2);
      step(2, 0, 4, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
      nop();
      chk("lit_rst_fwd_a", 32'(hif.Forward_A), 32'd0);
      chk("lit_rst_stall_count", 32'(hif.stall_count), 32'd0);
      chk("lit_rst_flush_count", 32'(hif.flush_count), 32'd0);
      chk("lit_rst_pc_write", 32'(hif.pc_write), 32'd1);

      // counter saturation
      for (int i = 0; i < 18; i++) begin
         lw(1, 2); alu(2, 5, 4); alu(2, 5, 4);
      end
      chk("lit_stall_saturate", 32'(hif.stall_count), 32'(CMAX));

      for (int i = 0; i < 3000; i++) begin
         bit mr;
         mr = ($urandom_range(0, 2) == 0);
         step($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7),
              mr | 1'($urandom_range(0, 1)), mr, 1'($urandom_range(0, 1)),
              ($urandom_range(0, 4) == 0), ($urandom_range(0, 49) != 0));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
